vga_pixel_fetch: RTL and testbench
==================================

// Module: vga_pixel_fetch
// PURPOSE
// - Downstream of the VGA timing generator (800x600 @ 1040x666 total, pixel coords /4 -> 200x150 logical).
// - Converts logical pixel coords to a framebuffer address and reads RGB332 colour from a sync-read framebuffer.
// - Delays hsync/vsync/visible by the same pipeline depth, so colour and sync leave the block aligned.
// - Expands the colour to the 12-bit VGA DAC. Reads the framebuffer once per logical pixel, not every clock.
// PARAMETERS
// - FB_W    200  logical pixels per line (address stride)
// - FB_H    150  logical lines per frame
// - ADDR_W  15   framebuffer address width (FB_W*FB_H <= 2**ADDR_W)
// - RD_LAT  1    framebuffer read latency in clk cycles, 1..4
// PORTS
// - clk          in   1       pixel clock, same clock as the timing generator
// - rst          in   1       synchronous, active-high reset
// - in_h_sync    in   1       hsync from timing gen, active low
// - in_v_sync    in   1       vsync from timing gen, active low
// - in_vis       in   1       visible-area flag
// - h_pixel      in   8       logical x, 0..FB_W-1 while in_vis
// - v_pixel      in   8       logical y, 0..FB_H-1 while in_vis
// - fb_rd_en     out  1       framebuffer read strobe
// - fb_addr      out  ADDR_W  read address = v_pixel*FB_W + h_pixel
// - fb_rdata     in   8       RGB332 {r[2:0],g[2:0],b[1:0]}, valid RD_LAT cycles after fb_rd_en
// - vga_hs       out  1       delayed hsync, active low
// - vga_vs       out  1       delayed vsync, active low
// - vga_r/g/b    out  4 each  DAC colour
// - frame_start  out  1       1-cycle pulse on falling edge of vga_vs
// BEHAVIOUR
// - Reset (clk edge with rst=1):
//   - fb_rd_en=0, fb_addr=0, vga_hs=1, vga_vs=1, vga_r/g/b=0, frame_start=0.
//   - Held colour=0. Every delay-line stage loads inactive values (sync=1, vis=0, rd_valid=0).
//   - rst asserted mid-line blanks output from the next cycle; the pipeline restarts clean and no stale read data is shown.
// - Stage 0 (issue), registered:
//   - fb_rd_en=1 when in_vis and (last cycle !in_vis, or h_pixel != last_h, or v_pixel != last_v).
//   - last_h/last_v update only on an issue.
//   - When fb_rd_en=1, fb_addr <= v_pixel*FB_W + h_pixel. Address arithmetic is computed at ADDR_W bits; no wrap for legal coords.
//   - When !in_vis, fb_rd_en=0 and fb_addr holds.
// - Total latency L = 1 + RD_LAT clocks from input to vga_* outputs. hs, vs, vis and rd_valid (=fb_rd_en) pass through L-stage shift registers.
// - Colour stage, at L:
//   - If rd_valid_L, the held colour loads fb_rdata and the output uses fb_rdata in that same cycle (bypass).
//   - Otherwise the output uses the held colour.
// - Blanking: vis_L=0 forces vga_r/g/b=0 regardless of the held colour.
// - Expansion: r={c[7:5],c[7]}, g={c[4:2],c[4]}, b={c[1:0],c[1:0]}. 0xFF gives F/F/F; 0x00 gives 0/0/0.
// - All vga_* outputs and frame_start are registered (no combinational path from inputs).
// - frame_start=1 for exactly one cycle when vs_L goes 1->0. It is aligned with the vga_vs edge.
// - Line start: the first visible cycle always issues a read, even if h_pixel equals last_h from the previous line.
// - Out-of-range coords while in_vis (h>=FB_W or v>=FB_H) are an upstream error; the address is computed anyway and no clamp is applied.
// CONFIGURATION
// - VGA_FETCH_TEST_PATTERN_EN defined:
//   - Adds input test_pattern (1 bit). While it is 1, fb_rd_en is forced to 0.
//   - Colour at stage L = 8 vertical bars: bar index = h_pixel[7:5] of that pixel, delayed L stages.
//   - Bar colour: r=idx[2]?F:0, g=idx[1]?F:0, b=idx[0]?F:0. Blanking and sync behaviour are unchanged.
// - Macro undefined: no test_pattern port; colour always comes from the framebuffer.
// TESTING
// - Reset: rst=1 for 3 cycles with in_vis=1 -> fb_rd_en=0, vga_hs=vga_vs=1, rgb=0 during reset and for L cycles after.
// - Fetch rate: hold v_pixel=3, sweep h_pixel 0..199 with 4 clocks each -> exactly 200 reads, addrs 600..799, each read on the first cycle of its pixel.
// - Latency: RD_LAT=1, fb_rdata=0xE0 returned at addr 600 -> vga_r=F, g=0, b=0 exactly 2 clocks after the input pixel. vga_hs edge is also shifted 2 clocks.
// - Blanking: in_vis=0 while the held colour is 0xFF -> rgb=0 and fb_rd_en=0. vis returning with h=0 on the same row -> a read is issued.
// - Frame pulse: in_v_sync falls once -> frame_start is high exactly 1 cycle, L cycles later, coincident with the vga_vs fall.
// - Latency sweep: repeat the latency case with RD_LAT=3 -> output at 4 clocks. With VGA_FETCH_TEST_PATTERN_EN and test_pattern=1, h=160 -> rgb=F/0/F and no reads.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch and DAC colour stage behind the VGA timing generator; sync and colour leave aligned.
// Optional build macro VGA_FETCH_TEST_PATTERN_EN adds a test_pattern input that shows 8 vertical colour bars.
module vga_pixel_fetch #(
    parameter int unsigned FB_W   = 200,
    parameter int unsigned FB_H   = 150,
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_h_sync,
    input  logic              in_v_sync,
    input  logic              in_vis,
    input  logic [7:0]        h_pixel,
    input  logic [7:0]        v_pixel,
`ifdef VGA_FETCH_TEST_PATTERN_EN
    input  logic              test_pattern,
`endif
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_rdata,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              frame_start
);

    generate
        if ((FB_W * FB_H) > (64'd1 << ADDR_W)) begin : g_bad_addr_w
            $error("vga_pixel_fetch: framebuffer does not fit in ADDR_W");
        end
        if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_bad_rd_lat
            $error("vga_pixel_fetch: RD_LAT must be 1..4");
        end
    endgenerate

    logic              last_vis;
    logic [7:0]        last_h;
    logic [7:0]        last_v;
    logic              issue_c;
    logic [ADDR_W-1:0] addr_c;

    // Stage 0: one read per logical pixel, always on the first visible cycle of a run
    always_comb begin
        issue_c = in_vis && (!last_vis || (h_pixel != last_h) || (v_pixel != last_v));
`ifdef VGA_FETCH_TEST_PATTERN_EN
        if (test_pattern) issue_c = 1'b0;
`endif
        addr_c = ADDR_W'(v_pixel) * ADDR_W'(FB_W) + ADDR_W'(h_pixel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_rd_en <= 1'b0;
            fb_addr  <= '0;
            last_vis <= 1'b0;
            last_h   <= '0;
            last_v   <= '0;
        end else begin
            fb_rd_en <= issue_c;
            last_vis <= in_vis;
            if (issue_c) begin
                fb_addr <= addr_c;
                last_h  <= h_pixel;
                last_v  <= v_pixel;
            end
        end
    end

    // Side-band delay lines; index RD_LAT is the cycle in which fb_rdata is valid
    logic [RD_LAT:0] hs_d;
    logic [RD_LAT:0] vs_d;
    logic [RD_LAT:0] vis_d;
    logic [RD_LAT:0] rv_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_d  <= '1;
            vs_d  <= '1;
            vis_d <= '0;
            rv_d  <= '0;
        end else begin
            hs_d  <= {hs_d[RD_LAT-1:0], in_h_sync};
            vs_d  <= {vs_d[RD_LAT-1:0], in_v_sync};
            vis_d <= {vis_d[RD_LAT-1:0], in_vis};
            rv_d  <= {rv_d[RD_LAT-1:0], issue_c};
        end
    end

`ifdef VGA_FETCH_TEST_PATTERN_EN
    logic [2:0]      bar_d [RD_LAT+1];
    logic [RD_LAT:0] tp_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            tp_d <= '0;
            for (int i = 0; i <= int'(RD_LAT); i++) bar_d[i] <= '0;
        end else begin
            tp_d     <= {tp_d[RD_LAT-1:0], test_pattern};
            bar_d[0] <= h_pixel[7:5];
            for (int i = 1; i <= int'(RD_LAT); i++) bar_d[i] <= bar_d[i-1];
        end
    end
`endif

    logic [7:0] held;
    logic [7:0] col_c;
    logic [3:0] r_c;
    logic [3:0] g_c;
    logic [3:0] b_c;

    // Colour select with same-cycle bypass of fresh read data, then expansion and blanking
    always_comb begin
        col_c = rv_d[RD_LAT] ? fb_rdata : held;
        r_c   = {col_c[7:5], col_c[7]};
        g_c   = {col_c[4:2], col_c[4]};
        b_c   = {col_c[1:0], col_c[1:0]};
`ifdef VGA_FETCH_TEST_PATTERN_EN
        if (tp_d[RD_LAT]) begin
            r_c = {4{bar_d[RD_LAT][2]}};
            g_c = {4{bar_d[RD_LAT][1]}};
            b_c = {4{bar_d[RD_LAT][0]}};
        end
`endif
        if (!vis_d[RD_LAT]) begin
            r_c = '0;
            g_c = '0;
            b_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held        <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            if (rv_d[RD_LAT]) held <= fb_rdata;
            vga_hs      <= hs_d[RD_LAT];
            vga_vs      <= vs_d[RD_LAT];
            vga_r       <= r_c;
            vga_g       <= g_c;
            vga_b       <= b_c;
            frame_start <= vga_vs & ~vs_d[RD_LAT];
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: RD_LAT=1 and RD_LAT=3 instances share stimulus, each with its own framebuffer model.
module tb_vga_pixel_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        hs, vs, vis;
    logic [7:0]  h, v;
`ifdef VGA_FETCH_TEST_PATTERN_EN
    logic        test_pattern;
`endif

    logic        a_rd, b_rd;
    logic [14:0] a_addr, b_addr;
    logic [7:0]  a_rdata, b_rdata;
    logic        a_hs, a_vs, a_fs, b_hs, b_vs, b_fs;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_pixel_fetch #(.RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .in_h_sync(hs), .in_v_sync(vs), .in_vis(vis),
        .h_pixel(h), .v_pixel(v),
`ifdef VGA_FETCH_TEST_PATTERN_EN
        .test_pattern(test_pattern),
`endif
        .fb_rd_en(a_rd), .fb_addr(a_addr), .fb_rdata(a_rdata),
        .vga_hs(a_hs), .vga_vs(a_vs), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .frame_start(a_fs)
    );

    vga_pixel_fetch #(.RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .in_h_sync(hs), .in_v_sync(vs), .in_vis(vis),
        .h_pixel(h), .v_pixel(v),
`ifdef VGA_FETCH_TEST_PATTERN_EN
        .test_pattern(test_pattern),
`endif
        .fb_rd_en(b_rd), .fb_addr(b_addr), .fb_rdata(b_rdata),
        .vga_hs(b_hs), .vga_vs(b_vs), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
        .frame_start(b_fs)
    );

    // Framebuffer contents; A5 marks cycles with no valid data
    function automatic logic [7:0] fb_fn(input logic [14:0] a);
        if (a == 15'd600) return 8'hE0;
        if (a == 15'd601) return 8'hFF;
        return a[7:0];
    endfunction

    always @(posedge clk) a_rdata <= a_rd ? fb_fn(a_addr) : 8'hA5;

    logic [7:0] sb0, sb1, sb2;
    always @(posedge clk) begin
        sb0 <= b_rd ? fb_fn(b_addr) : 8'hA5;
        sb1 <= sb0;
        sb2 <= sb1;
    end
    assign b_rdata = sb2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        vis;
        logic        hs;
        logic [7:0]  h;
        logic [7:0]  v;
        logic        rd;
        logic [14:0] addr;
        logic [11:0] a_rgb;
        logic        a_hs;
        logic [11:0] b_rgb;
        logic        b_hs;
    } vec_t;

    vec_t tbl [16];

    initial begin
        // vis hs h v | rd addr | a_rgb a_hs | b_rgb b_hs  (a shows row k-2, b shows row k-4)
        tbl[0]  = '{1'b1, 1'b1, 8'd0,   8'd3,   1'b1, 15'd600,   12'h000, 1'b1, 12'h000, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 8'd0,   8'd3,   1'b0, 15'd600,   12'h000, 1'b1, 12'h000, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 8'd1,   8'd3,   1'b1, 15'd601,   12'hF00, 1'b1, 12'h000, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 8'd1,   8'd3,   1'b0, 15'd601,   12'hF00, 1'b1, 12'h000, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 8'd1,   8'd3,   1'b0, 15'd601,   12'hFFF, 1'b1, 12'hF00, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 8'd1,   8'd3,   1'b0, 15'd601,   12'hFFF, 1'b1, 12'hF00, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 8'd1,   8'd3,   1'b0, 15'd601,   12'h000, 1'b0, 12'hFFF, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 8'd1,   8'd3,   1'b1, 15'd601,   12'h000, 1'b0, 12'hFFF, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 8'd1,   8'd3,   1'b0, 15'd601,   12'h000, 1'b1, 12'h000, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 8'd2,   8'd3,   1'b1, 15'd602,   12'hFFF, 1'b1, 12'h000, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 8'd2,   8'd4,   1'b1, 15'd802,   12'hFFF, 1'b1, 12'h000, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 8'd199, 8'd149, 1'b1, 15'd29999, 12'h4DA, 1'b1, 12'hFFF, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 8'd199, 8'd149, 1'b0, 15'd29999, 12'h20A, 1'b1, 12'hFFF, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 8'd0,   8'd0,   1'b0, 15'd29999, 12'h26F, 1'b1, 12'h4DA, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 8'd0,   8'd0,   1'b0, 15'd29999, 12'h26F, 1'b1, 12'h20A, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 8'd0,   8'd0,   1'b0, 15'd29999, 12'h000, 1'b1, 12'h26F, 1'b1};

        hs = 1'b1; vs = 1'b1; vis = 1'b1; h = 8'd5; v = 8'd0;
`ifdef VGA_FETCH_TEST_PATTERN_EN
        test_pattern = 1'b0;
`endif

        // Reset held with in_vis=1
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_rd_en", 32'(a_rd), 32'd0);
            chk("rst_addr", 32'(a_addr), 32'd0);
            chk("rst_hs_vs", {30'd0, a_hs, a_vs}, 32'd3);
            chk("rst_rgb_a", {20'd0, a_r, a_g, a_b}, 32'h000);
            chk("rst_rgb_b", {20'd0, b_r, b_g, b_b}, 32'h000);
            chk("rst_fs", {30'd0, a_fs, b_fs}, 32'd0);
        end
        rst = 1'b0;
        // Pipeline stays blank for L cycles; fb(5)=0x05 -> 0/2/5
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_rd", 32'(a_rd), (i == 0) ? 32'd1 : 32'd0);
            if (i == 0) chk("post_rst_addr", 32'(a_addr), 32'd5);
            chk("post_rst_rgb_a", {20'd0, a_r, a_g, a_b}, (i < 2) ? 32'h000 : 32'h025);
            chk("post_rst_rgb_b", {20'd0, b_r, b_g, b_b}, (i < 4) ? 32'h000 : 32'h025);
        end

        vis = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Directed vector table: fetch, latency, bypass/hold, blanking, line start, bounds
        for (int k = 0; k < 16; k++) begin
            vis = tbl[k].vis; hs = tbl[k].hs; h = tbl[k].h; v = tbl[k].v;
            step();
            chk($sformatf("tbl%0d_rd", k), 32'(a_rd), 32'(tbl[k].rd));
            chk($sformatf("tbl%0d_addr", k), 32'(a_addr), 32'(tbl[k].addr));
            chk($sformatf("tbl%0d_rd_b", k), 32'(b_rd), 32'(tbl[k].rd));
            chk($sformatf("tbl%0d_rgb_a", k), {20'd0, a_r, a_g, a_b}, 32'(tbl[k].a_rgb));
            chk($sformatf("tbl%0d_hs_a", k), 32'(a_hs), 32'(tbl[k].a_hs));
            chk($sformatf("tbl%0d_rgb_b", k), {20'd0, b_r, b_g, b_b}, 32'(tbl[k].b_rgb));
            chk($sformatf("tbl%0d_hs_b", k), 32'(b_hs), 32'(tbl[k].b_hs));
        end

        vis = 1'b0; hs = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Fetch rate: one read on the first of 4 clocks per logical pixel
        begin
            int reads;
            reads = 0;
            for (int x = 0; x < 200; x++) begin
                for (int j = 0; j < 4; j++) begin
                    vis = 1'b1; v = 8'd3; h = 8'(x);
                    step();
                    chk("rate_rd_en", 32'(a_rd), (j == 0) ? 32'd1 : 32'd0);
                    if (a_rd) begin
                        reads++;
                        chk("rate_addr", 32'(a_addr), 32'(600 + x));
                    end
                end
            end
            vis = 1'b0;
            step();
            chk("rate_reads", 32'(reads), 32'd200);
        end

        for (int i = 0; i < 6; i++) step();

        // Frame pulse: single vsync fall
        vs = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("fs_a", 32'(a_fs), (i == 2) ? 32'd1 : 32'd0);
            chk("vs_a", 32'(a_vs), (i < 2) ? 32'd1 : 32'd0);
            chk("fs_b", 32'(b_fs), (i == 4) ? 32'd1 : 32'd0);
            chk("vs_b", 32'(b_vs), (i < 4) ? 32'd1 : 32'd0);
        end
        vs = 1'b1;
        for (int i = 0; i < 6; i++) step();

`ifdef VGA_FETCH_TEST_PATTERN_EN
        // Test pattern: bar 5 at h=160 -> F/0/F, no reads
        test_pattern = 1'b1; vis = 1'b1; h = 8'd160; v = 8'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("tp_rd_a", 32'(a_rd), 32'd0);
            chk("tp_rd_b", 32'(b_rd), 32'd0);
            chk("tp_rgb_a", {20'd0, a_r, a_g, a_b}, (i < 2) ? 32'h000 : 32'hF0F);
            chk("tp_rgb_b", {20'd0, b_r, b_g, b_b}, (i < 4) ? 32'h000 : 32'hF0F);
        end
        test_pattern = 1'b0; vis = 1'b0;
        for (int i = 0; i < 6; i++) step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
